// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam byte_t       GF_RED    = 8'h1B;
  // Row 0 of the InvMixColumns circulant; row r is this rotated right by r bytes.
  localparam logic [31:0] IMC_COEFS = 32'h0E0B0D09;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ p) : acc;
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Byte k sits at [127-8k -: 8]; output row r, column c takes input column (c-r) mod 4.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion (0 maps to 0).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  byte_t aff_s;

  // x^254 equals x^-1 for nonzero x and yields 0 for x = 0.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t x2, x3, x6, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) begin
      x240 = gf_mul(x240, x240);
    end
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  // Bit i of the affine result is din[i+2] ^ din[i+5] ^ din[i+7] ^ 0x05[i], indices mod 8.
  assign aff_s = {din[1:0], din[7:2]} ^ {din[4:0], din[7:5]} ^ {din[6:0], din[7]} ^ 8'h05;
  assign dout  = gf_inv(aff_s);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one inverse round per clock, external round-key store.
// Optional abort input enabled by defining AES_INV_CIPHER_ABORT_EN.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_CIPHER_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  generate
    if (NR != 32'sd10 && NR != 32'sd12 && NR != 32'sd14) begin : g_bad_nr
      $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ROUND = ROUND;
  localparam logic [1:0] S_DONE  = DONE;
  localparam logic [3:0] NR_IDX  = NR[3:0];

  logic [1:0] fsm_r;
  logic [3:0] cnt_r;
  state_t     state_r;
  state_t     out_data_r;
  logic       out_valid_r;
  logic       abort_s;
  state_t     isr_s;
  state_t     isb_s;
  state_t     ark_s;
  state_t     imc_s;
  byte_t      acc_s;

`ifdef AES_INV_CIPHER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign isr_s = inv_shift_rows(state_r);

  generate
    for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_inv_sbox u_sbox (
        .din  (isr_s[127-8*i -: 8]),
        .dout (isb_s[127-8*i -: 8])
      );
    end
  endgenerate

  assign ark_s = isb_s ^ rk;

  // InvMixColumns over each column of the key-added state
  always_comb begin
    imc_s = 128'd0;
    acc_s = 8'h00;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc_s = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc_s = acc_s ^ gf_mul(IMC_COEFS[31-8*((j-r+4)%4) -: 8], ark_s[127-8*(4*c+j) -: 8]);
        end
        imc_s[127-8*(4*c+r) -: 8] = acc_s;
      end
    end
  end

  assign in_ready  = (fsm_r == S_IDLE);
  assign rk_idx    = (fsm_r == S_ROUND) ? cnt_r : NR_IDX;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Control FSM, round counter and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= S_IDLE;
      cnt_r       <= 4'd0;
      state_r     <= 128'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 128'd0;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          if (in_valid) begin
            state_r <= in_data ^ rk;
            cnt_r   <= NR_IDX - 4'd1;
            fsm_r   <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort_s) begin
            fsm_r       <= S_IDLE;
            out_valid_r <= 1'b0;
          end else if (cnt_r != 4'd0) begin
            state_r <= imc_s;
            cnt_r   <= cnt_r - 4'd1;
          end else begin
            out_data_r  <= ark_s;
            out_valid_r <= 1'b1;
            fsm_r       <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort_s || out_ready) begin
            out_valid_r <= 1'b0;
            fsm_r       <= S_IDLE;
          end
        end
        default: begin
          fsm_r       <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher (decryption) datapath; one inverse round per clock.
- Mirror of the encrypt-side round path: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns applied to the same column-major 128-bit state layout.
- Sits between the ciphertext source (valid/ready) and the plaintext sink (valid/ready).
- Round keys come from an external key-schedule store, addressed by this block.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  block can accept ciphertext.
- in_data  in  128  ciphertext; [127:120]=S0 … [7:0]=S15, column-major (S0..S3 = column 0).
- rk_idx  out  4  round-key index requested this cycle.
- rk  in  128  round key for rk_idx; combinational, same cycle, same byte layout.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  sink accepts plaintext.
- out_data  out  128  plaintext, same layout.

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE, round counter=0, state register=0, out_valid=0, out_data=0. in_ready=1 the cycle after reset releases.
- FSM states:
  - IDLE: in_ready=1, rk_idx=NR. On in_valid&&in_ready: state <= in_data ^ rk; cnt <= NR-1; go to ROUND.
  - ROUND: in_ready=0, rk_idx=cnt.
    - cnt>0: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk); cnt <= cnt-1.
    - cnt==0 (final round): out_data <= InvSubBytes(InvShiftRows(state)) ^ rk; out_valid <= 1; go to DONE.
  - DONE: out_valid=1, out_data stable. On out_ready: out_valid <= 0; go to IDLE. Otherwise hold indefinitely.
- Latency: if the accept is cycle 0, ROUND occupies cycles 1..NR and out_valid is first high in cycle NR+1.
- Minimum accept-to-accept period (out_ready held 1): NR+2 cycles.
- InvShiftRows output byte order: {S0,S13,S10,S7, S4,S1,S14,S11, S8,S5,S2,S15, S12,S9,S6,S3}. Row r is rotated right by r bytes.
- InvSubBytes: inverse S-box per byte. Implementation: inverse affine transform, then GF(2^8) inversion mod x^8+x^4+x^3+x+1, with 0 mapping to 0. No 256-entry table.
- InvMixColumns: per column, matrix [0e 0b 0d 09] circulant over GF(2^8).
- Boundary conditions:
  - in_valid outside IDLE is ignored; in_data is not sampled.
  - rk is sampled only in IDLE on accept, and in ROUND; rk_idx is don't-care in DONE but must be held at NR.
  - rst_n low in any state: abandon the operation, return to IDLE next edge, out_valid=0.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: AES_INV_CIPHER_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in ROUND or DONE: go to IDLE next edge, out_valid <= 0, no plaintext emitted; state register is left unchanged.
  - abort in IDLE is ignored.
  - abort wins over out_ready in DONE.
- Undefined: no abort port; the FSM is exactly as above.

Decomposition:
- Shared package aes_pkg:
  - state type (128-bit) and byte type;
  - FSM enum {IDLE, ROUND, DONE};
  - GF(2^8) reduction constant 8'h1B;
  - InvMixColumns coefficients;
  - functions xtime and gf_mul, and the InvShiftRows byte-permutation function.
- Sub-module: aes_inv_sbox (8-bit in, 8-bit out, combinational), instantiated 16 times.
- InvMixColumns stays inline, using package functions.

Test Plan:
- FIPS-197 C.1: key 000102…0f (bench key-schedule model drives rk), in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid first high exactly 11 cycles after accept. rk_idx sequence: 10 at accept, then 9,8,…,0.
- NR=14, FIPS-197 C.3: key 000102…1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff, latency 15.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable and in_ready=0 throughout. Then release; in_ready=1 the next cycle.
- in_valid pulsed during ROUND with random data -> ignored; result still matches C.1. Back-to-back C.1 vectors with out_ready=1 -> accept spacing 12 cycles.
- rst_n=0 for one cycle mid-ROUND (cnt=5) -> next cycle IDLE, out_valid=0, in_ready=1. A new C.1 vector then decrypts correctly.
- With AES_INV_CIPHER_ABORT_EN, abort at cycle 4 after accept -> IDLE next cycle, out_valid never asserted. abort=1 with out_ready=1 in DONE -> no handshake; out_valid drops.
